// File: rtl/ccm_pkg.sv
// ccm_pkg: shared widths, coefficient types and the output saturation helper.
// Latency: n/a (types and functions only).
// Backpressure: n/a.
package ccm_pkg;

  localparam int CCM_PX_WIDTH   = 10;
  localparam int CCM_COEF_WIDTH = 12;
  localparam int CCM_COEF_FRAC  = 8;

  typedef logic signed [CCM_COEF_WIDTH-1:0] coef_t;
  // [i][j] = output channel i from input channel j; bit layout equals the flat coefficient bus.
  typedef coef_t [2:0][2:0] coef_mat_t;

  localparam coef_t CCM_ONE  = coef_t'(1 << CCM_COEF_FRAC);
  localparam coef_t CCM_ZERO = coef_t'(0);

  // Unity gain on the diagonal, no cross-channel mixing.
  localparam coef_mat_t CCM_IDENTITY = coef_mat_t'({CCM_ONE,  CCM_ZERO, CCM_ZERO,
                                                    CCM_ZERO, CCM_ONE,  CCM_ZERO,
                                                    CCM_ZERO, CCM_ZERO, CCM_ONE});

  // Saturate a signed result into an unsigned px_w-bit range; the caller truncates to px_w.
  function automatic logic [31:0] ccm_clip(input logic signed [47:0] r, input int px_w);
    logic signed [47:0] max_v;
    max_v = (48'sd1 <<< px_w) - 48'sd1;
    if (r < 0) begin
      return '0;
    end else if (r > max_v) begin
      return 32'(max_v);
    end else begin
      return 32'(r);
    end
  endfunction

endpackage

// File: rtl/axi4_stream_if.sv
// axi4_stream_if: AXI4-Stream signal bundle with master/slave views.
// Latency: n/a (wires only).
// Backpressure: tready from slave to master.
interface axi4_stream_if #(
  parameter int TDATA_W = 32
) ();
  logic                   tvalid;
  logic                   tready;
  logic [TDATA_W-1:0]     tdata;
  logic [TDATA_W/8-1:0]   tkeep;
  logic [TDATA_W/8-1:0]   tstrb;
  logic                   tlast;
  logic                   tuser;
  logic                   tid;
  logic                   tdest;

  modport master (output tvalid, tdata, tkeep, tstrb, tlast, tuser, tid, tdest, input tready);
  modport slave  (input tvalid, tdata, tkeep, tstrb, tlast, tuser, tid, tdest, output tready);
endinterface

// File: rtl/ccm_dot3.sv
// ccm_dot3: one colour-matrix output row -- 3 signed products, rounded sum, shift and clip.
// Latency: 3 cycles (product, sum, clip registers).
// Backpressure: every stage holds its contents while adv_i is low.
module ccm_dot3 import ccm_pkg::*; #(
  parameter int PX_WIDTH   = CCM_PX_WIDTH,
  parameter int COEF_WIDTH = CCM_COEF_WIDTH,
  parameter int COEF_FRAC  = CCM_COEF_FRAC
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    adv_i,
  input  logic [3*COEF_WIDTH-1:0] coef_row_i,
  input  logic [3*PX_WIDTH-1:0]   px_i,
  output logic [PX_WIDTH-1:0]     dat_o
);

  // Product of a signed coefficient and a zero-extended pixel, plus 2 bits of sum growth.
  localparam int PW = PX_WIDTH + COEF_WIDTH + 1;
  localparam int SW = PW + 2;
  // Half an LSB of the output, so the later arithmetic shift rounds half up.
  localparam logic signed [SW-1:0] RND = SW'(1) << (COEF_FRAC - 1);

  logic signed [PW-1:0]   prod_d [3];
  logic signed [PW-1:0]   prod_q [3];
  logic signed [SW-1:0]   sum_d;
  logic signed [SW-1:0]   sum_q;
  logic signed [SW-1:0]   shf;
  logic [PX_WIDTH-1:0]    dat_d;
  logic [PX_WIDTH-1:0]    dat_q;

  // Stage 1 inputs: the three per-channel products, full precision.
  always_comb begin
    for (int j = 0; j < 3; j++) begin
      prod_d[j] = PW'($signed(coef_row_i[j*COEF_WIDTH +: COEF_WIDTH]))
                * PW'($signed({1'b0, px_i[j*PX_WIDTH +: PX_WIDTH]}));
    end
  end

  assign sum_d = SW'(prod_q[0]) + SW'(prod_q[1]) + SW'(prod_q[2]) + RND;
  assign shf   = sum_q >>> COEF_FRAC;
  assign dat_d = PX_WIDTH'(ccm_clip(48'(shf), PX_WIDTH));

  // Advance all three stages together; hold everything while the output is stalled.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int j = 0; j < 3; j++) begin
        prod_q[j] <= '0;
      end
      sum_q <= '0;
      dat_q <= '0;
    end else if (adv_i) begin
      for (int j = 0; j < 3; j++) begin
        prod_q[j] <= prod_d[j];
      end
      sum_q <= sum_d;
      dat_q <= dat_d;
    end
  end

  assign dat_o = dat_q;

endmodule

// File: rtl/rgb_color_correction_3x3.sv
// rgb_color_correction_3x3: programmable 3x3 colour matrix on an RGB stream, coefficients swap only at frame start.
// Latency: 3 advancing cycles, identical for matrix and pass-through modes.
// Backpressure: whole pipeline stalls when the output holds an unaccepted beat; input ready mirrors that.
module rgb_color_correction_3x3 import ccm_pkg::*; #(
  parameter int PX_WIDTH   = CCM_PX_WIDTH,
  parameter int COEF_WIDTH = CCM_COEF_WIDTH,
  parameter int COEF_FRAC  = CCM_COEF_FRAC
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    ccm_en_i,
  input  logic [9*COEF_WIDTH-1:0] ccm_coef_i,
  output logic [9*COEF_WIDTH-1:0] ccm_coef_act_o,
  axi4_stream_if.slave            video_i,
  axi4_stream_if.master           video_o
);

  localparam int TDATA_W = ((3*PX_WIDTH + 7) / 8) * 8;
  localparam int CW9     = 9 * COEF_WIDTH;

  function automatic logic [CW9-1:0] identity_mat();
    logic [CW9-1:0] m;
    m = '0;
    for (int i = 0; i < 3; i++) begin
      m[(4*i)*COEF_WIDTH +: COEF_WIDTH] = COEF_WIDTH'(1) << COEF_FRAC;
    end
    return m;
  endfunction

  localparam logic [CW9-1:0] IDENTITY = identity_mat();

  logic                  adv;
  logic                  accept;
  logic                  capture;
  logic [CW9-1:0]        coef_act_q;
  logic [CW9-1:0]        coef_use;
  logic                  en_act_q;
  logic                  en_use;
  logic [2:0]            vld_q;
  logic [2:0]            last_q;
  logic [2:0]            user_q;
  logic [2:0]            en_q;
  logic [3*PX_WIDTH-1:0] px_q [3];
  logic [3*PX_WIDTH-1:0] px_in;
  logic [3*PX_WIDTH-1:0] ccm_px;
  logic                  unused_in;

  assign adv            = !vld_q[2] || video_o.tready;
  assign video_i.tready = adv;
  assign accept         = video_i.tvalid && adv;
  assign capture        = accept && video_i.tuser;

  // The frame-start beat itself must already see the newly captured set.
  assign coef_use = capture ? ccm_coef_i : coef_act_q;
  assign en_use   = capture ? ccm_en_i   : en_act_q;
  assign px_in    = video_i.tdata[3*PX_WIDTH-1:0];

  // Sideband fields this block neither needs nor forwards.
  assign unused_in = ^{video_i.tdata, video_i.tkeep, video_i.tstrb, video_i.tid, video_i.tdest};

  // Shadow register: latch coefficients and enable only on an accepted frame-start beat.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      coef_act_q <= IDENTITY;
      en_act_q   <= 1'b0;
    end else if (capture) begin
      coef_act_q <= ccm_coef_i;
      en_act_q   <= ccm_en_i;
    end
  end

  // Valid, sideband, per-beat enable and raw pixel travel in lockstep with the dot-product stages.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      vld_q  <= '0;
      last_q <= '0;
      user_q <= '0;
      en_q   <= '0;
      for (int k = 0; k < 3; k++) begin
        px_q[k] <= '0;
      end
    end else if (adv) begin
      vld_q   <= {vld_q[1:0],  video_i.tvalid};
      last_q  <= {last_q[1:0], video_i.tvalid && video_i.tlast};
      user_q  <= {user_q[1:0], video_i.tvalid && video_i.tuser};
      en_q    <= {en_q[1:0],   en_use};
      px_q[0] <= px_in;
      px_q[1] <= px_q[0];
      px_q[2] <= px_q[1];
    end
  end

  for (genvar i = 0; i < 3; i++) begin : g_row
    ccm_dot3 #(
      .PX_WIDTH   (PX_WIDTH),
      .COEF_WIDTH (COEF_WIDTH),
      .COEF_FRAC  (COEF_FRAC)
    ) u_dot3 (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .adv_i      (adv),
      .coef_row_i (coef_use[3*i*COEF_WIDTH +: 3*COEF_WIDTH]),
      .px_i       (px_in),
      .dat_o      (ccm_px[i*PX_WIDTH +: PX_WIDTH])
    );
  end

  // Both mux inputs come straight from registers, so the output is stable while stalled.
  assign video_o.tvalid = vld_q[2];
  assign video_o.tdata  = TDATA_W'(en_q[2] ? ccm_px : px_q[2]);
  assign video_o.tlast  = last_q[2];
  assign video_o.tuser  = user_q[2];
  assign video_o.tkeep  = '1;
  assign video_o.tstrb  = '1;
  assign video_o.tid    = 1'b0;
  assign video_o.tdest  = 1'b0;
  assign ccm_coef_act_o = coef_act_q;

endmodule

// File: tb/tb_rgb_color_correction_3x3.sv
`timescale 1ns/1ps
module tb_rgb_color_correction_3x3;
  import ccm_pkg::*;

  localparam int PX   = 10;
  localparam int CW   = 12;
  localparam int FRAC = 8;
  localparam int TW   = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ccm_en;
  logic [9*CW-1:0] ccm_coef;
  logic [9*CW-1:0] coef_act;

  axi4_stream_if #(.TDATA_W(TW)) vin ();
  axi4_stream_if #(.TDATA_W(TW)) vout ();

  rgb_color_correction_3x3 #(
    .PX_WIDTH   (PX),
    .COEF_WIDTH (CW),
    .COEF_FRAC  (FRAC)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst_n),
    .ccm_en_i       (ccm_en),
    .ccm_coef_i     (ccm_coef),
    .ccm_coef_act_o (coef_act),
    .video_i        (vin),
    .video_o        (vout)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit rand_rdy = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // Coefficient bus from row-major values c00,c01,c02,c10,...,c22.
  function automatic logic [9*CW-1:0] mkc(input int a0, input int a1, input int a2,
                                          input int a3, input int a4, input int a5,
                                          input int a6, input int a7, input int a8);
    return {CW'(a8), CW'(a7), CW'(a6), CW'(a5), CW'(a4), CW'(a3), CW'(a2), CW'(a1), CW'(a0)};
  endfunction

  function automatic logic [3*PX-1:0] mkp(input int r, input int g, input int b);
    return {PX'(b), PX'(g), PX'(r)};
  endfunction

  function automatic logic [TW-1:0] rnd_px();
    return TW'(mkp(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
                   int'($urandom_range(0, 1023))));
  endfunction

  // Reference: integer dot product, +0.5 LSB, floor divide by 2^FRAC, saturate to pixel range.
  function automatic logic [TW-1:0] model(input logic [9*CW-1:0] c, input bit en, input logic [TW-1:0] d);
    int px [3];
    int s;
    int q;
    logic [TW-1:0] o;
    o = '0;
    for (int k = 0; k < 3; k++) px[k] = int'(d[k*PX +: PX]);
    if (!en) begin
      o[3*PX-1:0] = d[3*PX-1:0];
      return o;
    end
    for (int i = 0; i < 3; i++) begin
      s = 0;
      for (int j = 0; j < 3; j++) s += int'($signed(c[(3*i+j)*CW +: CW])) * px[j];
      s += 2 ** (FRAC - 1);
      if (s >= 0) q = s / (2 ** FRAC);
      else        q = -((-s + (2 ** FRAC) - 1) / (2 ** FRAC));
      if (q < 0)    q = 0;
      if (q > 1023) q = 1023;
      o[i*PX +: PX] = PX'(q);
    end
    return o;
  endfunction

  // ---------------- scoreboard / monitor ----------------
  typedef struct packed {
    logic [TW-1:0] dat;
    logic          last;
    logic          user;
  } beat_t;

  beat_t           exp_q[$];
  logic [9*CW-1:0] m_coef;
  bit              m_en;
  bit              hold_vld;
  beat_t           hold_b;

  always @(negedge clk) begin
    beat_t b;
    if (!rst_n) begin
      exp_q.delete();
      m_coef   = CCM_IDENTITY;
      m_en     = 1'b0;
      hold_vld = 1'b0;
    end else begin
      if (hold_vld) begin
        check("hold_tvalid", 128'(vout.tvalid), 128'(1));
        check("hold_beat", 128'({vout.tdata, vout.tlast, vout.tuser}), 128'(hold_b));
      end
      hold_vld = vout.tvalid && !vout.tready;
      hold_b   = {vout.tdata, vout.tlast, vout.tuser};
      if (vout.tvalid && vout.tready) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL extra_beat: actual %0h required none", vout.tdata);
        end else begin
          b = exp_q.pop_front();
          n_tests--;
          check("out_beat", 128'({vout.tdata, vout.tlast, vout.tuser}), 128'(b));
        end
      end
      if (vin.tvalid && vin.tready) begin
        if (vin.tuser) begin
          m_coef = ccm_coef;
          m_en   = ccm_en;
        end
        exp_q.push_back({model(m_coef, m_en, vin.tdata), vin.tlast, vin.tuser});
      end
    end
  end

  // Output ready: always high for directed tests, 50% random otherwise.
  initial begin
    vout.tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      vout.tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- driver helpers ----------------
  // Present one beat at posedge+1, return at posedge+1 just after it was accepted.
  task automatic send(input logic user, input logic last, input logic [TW-1:0] dat);
    int waitc;
    waitc = 0;
    vin.tvalid = 1'b1;
    vin.tuser  = user;
    vin.tlast  = last;
    vin.tdata  = dat;
    @(negedge clk);
    while (!vin.tready && waitc < 200) begin
      @(negedge clk);
      waitc++;
    end
    if (!vin.tready) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: actual tready=0 required 1");
    end
    @(posedge clk);
    #1;
    vin.tvalid = 1'b0;
    vin.tuser  = 1'b0;
    vin.tlast  = 1'b0;
  endtask

  // Step edges until the output is valid (optionally with tuser); returns edges counted from the accept edge.
  task automatic wait_out(input bit need_user, output int lat);
    lat = 1;
    while (!(vout.tvalid && (vout.tuser || !need_user)) && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  typedef struct packed {
    logic            en;
    logic [9*CW-1:0] c;
    logic [3*PX-1:0] pin;
    logic [3*PX-1:0] pexp;
  } vec_t;

  vec_t vecs [10];

  initial begin
    logic [9*CW-1:0] id_c;
    logic [9*CW-1:0] swap_c;
    int lat;

    id_c   = mkc(256, 0, 0,   0, 256, 0,   0, 0, 256);
    swap_c = mkc(0, 0, 256,   0, 256, 0,   256, 0, 0);

    vecs[0] = {1'b1, id_c, mkp(100, 200, 300), mkp(100, 200, 300)};
    vecs[1] = {1'b1, mkc(512, 0, 0, 0, 256, 0, 0, 0, 256), mkp(600, 5, 7), mkp(1023, 5, 7)};
    vecs[2] = {1'b1, mkc(256, -256, 0, 0, 256, 0, 0, 0, 256), mkp(100, 200, 50), mkp(0, 200, 50)};
    vecs[3] = {1'b1, mkc(128, 0, 0, 0, 256, 0, 0, 0, 256), mkp(3, 9, 9), mkp(2, 9, 9)};
    vecs[4] = {1'b1, mkc(128, 0, 0, 0, 256, 0, 0, 0, 256), mkp(1, 9, 9), mkp(1, 9, 9)};
    vecs[5] = {1'b1, mkc(128, 0, 0, 0, 256, 0, 0, 0, 256), mkp(2, 9, 9), mkp(1, 9, 9)};
    vecs[6] = {1'b1, mkc(256, 0, 0, 77, 150, 29, 0, 0, 256), mkp(1000, 500, 20), mkp(1000, 596, 20)};
    vecs[7] = {1'b0, swap_c, mkp(11, 22, 33), mkp(11, 22, 33)};
    vecs[8] = {1'b1, swap_c, mkp(11, 22, 33), mkp(33, 22, 11)};
    vecs[9] = {1'b1, mkc(2047, 2047, 2047, -2048, -2048, -2048, 0, 0, 0),
               mkp(1023, 1023, 1023), mkp(1023, 0, 0)};

    rst_n      = 1'b0;
    ccm_en     = 1'b0;
    ccm_coef   = '0;
    vin.tvalid = 1'b0;
    vin.tdata  = '0;
    vin.tlast  = 1'b0;
    vin.tuser  = 1'b0;
    vin.tkeep  = '1;
    vin.tstrb  = '1;
    vin.tid    = 1'b0;
    vin.tdest  = 1'b0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_tvalid", 128'(vout.tvalid), 128'(0));
    check("rst_tdata",  128'(vout.tdata),  128'(0));
    check("rst_side",   128'({vout.tlast, vout.tuser}), 128'(0));
    check("rst_coef",   128'(coef_act), 128'(CCM_IDENTITY));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("keep_strb_id_dest", 128'({vout.tkeep, vout.tstrb, vout.tid, vout.tdest}), 128'(10'b1111111100));

    // Single-pixel frames (tuser and tlast together): latency, arithmetic, rounding and clip rails.
    for (int v = 0; v < 10; v++) begin
      ccm_en   = vecs[v].en;
      ccm_coef = vecs[v].c;
      send(1'b1, 1'b1, TW'(vecs[v].pin));
      wait_out(1'b0, lat);
      check($sformatf("vec%0d_latency", v), 128'(lat), 128'(3));
      check($sformatf("vec%0d_data", v), 128'(vout.tdata), 128'(TW'(vecs[v].pexp)));
      check($sformatf("vec%0d_user_last", v), 128'({vout.tuser, vout.tlast}), 128'(2'b11));
      check($sformatf("vec%0d_coef_act", v), 128'(coef_act), 128'(vecs[v].c));
    end

    // Mid-frame coefficient write is ignored until the next frame start.
    ccm_en   = 1'b1;
    ccm_coef = id_c;
    for (int b = 0; b < 8; b++) begin
      if (b == 5) ccm_coef = swap_c;
      send(b == 0, b == 7, rnd_px());
    end
    check("midframe_coef_act", 128'(coef_act), 128'(id_c));
    send(1'b1, 1'b0, TW'(mkp(1, 2, 3)));
    wait_out(1'b1, lat);
    check("nextframe_swapped", 128'(vout.tdata), 128'(TW'(mkp(3, 2, 1))));
    check("nextframe_coef_act", 128'(coef_act), 128'(swap_c));
    send(1'b0, 1'b1, TW'(mkp(4, 5, 6)));
    repeat (6) @(posedge clk);
    #1;

    // Two random 8x4 frames with random output stalls and input bubbles.
    rand_rdy = 1'b1;
    for (int f = 0; f < 2; f++) begin
      ccm_en = 1'b1;
      for (int k = 0; k < 9; k++) begin
        ccm_coef[k*CW +: CW] = (f == 0) ? CW'(int'($urandom_range(0, 1023)) - 384)
                                        : CW'($urandom_range(0, 4095));
      end
      for (int y = 0; y < 4; y++) begin
        for (int x = 0; x < 8; x++) begin
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
          send(x == 0 && y == 0, x == 7, rnd_px());
          ccm_coef[0 +: CW] = CW'($urandom_range(0, 4095));
        end
      end
    end
    for (int w = 0; w < 500 && exp_q.size() != 0; w++) begin
      @(posedge clk);
      #1;
    end
    check("random_drain", 128'(exp_q.size()), 128'(0));
    rand_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset with beats in flight: output drops at once, active set reverts to identity/bypass.
    ccm_en   = 1'b1;
    ccm_coef = swap_c;
    send(1'b1, 1'b0, TW'(mkp(10, 20, 30)));
    send(1'b0, 1'b0, TW'(mkp(11, 21, 31)));
    send(1'b0, 1'b0, TW'(mkp(12, 22, 32)));
    check("pre_reset_tvalid", 128'(vout.tvalid), 128'(1));
    rst_n = 1'b0;
    #1;
    check("reset_tvalid", 128'(vout.tvalid), 128'(0));
    check("reset_coef_act", 128'(coef_act), 128'(CCM_IDENTITY));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_reset_idle", 128'(vout.tvalid), 128'(0));
    send(1'b0, 1'b1, TW'(mkp(5, 6, 7)));
    wait_out(1'b0, lat);
    check("post_reset_bypass", 128'(vout.tdata), 128'(TW'(mkp(5, 6, 7))));
    ccm_coef = id_c;
    send(1'b1, 1'b1, TW'(mkp(40, 50, 60)));
    wait_out(1'b1, lat);
    check("post_reset_frame", 128'(vout.tdata), 128'(TW'(mkp(40, 50, 60))));
    check("post_reset_coef_act", 128'(coef_act), 128'(id_c));

    repeat (5) @(posedge clk);
    #1;
    check("final_drain", 128'(exp_q.size()), 128'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
